// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the HD44780-style LCD bus scheduler.
//   lcd_state_e : sequencer states
//   lcd_xfer_t  : one bus transfer {rs, data}
//   LCD_*       : command byte constants
//   lcd_max     : integer max, used to size the shared down-counter
//   lcd_is_long : selects the long post-strobe wait (clear / home commands)
// Optional feature macro: LCD_INIT_SEQ_EN adds the ST_INIT state and the
// power-up init ROM.
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5
`ifdef LCD_INIT_SEQ_EN
        , ST_INIT = 3'd6
`endif
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_xfer_t;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

`ifdef LCD_INIT_SEQ_EN
    localparam int LCD_INIT_LEN = 4;
    localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{
        LCD_FUNC_8B2L, LCD_DISP_ON, LCD_ENTRY_INC, LCD_CLEAR
    };
`endif

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) are the only commands with
    // data[7:2] == 0; they need the long execution wait.
    function automatic logic lcd_is_long(input lcd_xfer_t x);
        return (!x.rs) && (x.data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// ---------------------------------------------------------------------------
// lcd_rr_arb
// Two-way round-robin arbiter. Grant is combinational from i_valid and the
// last-grant pointer; the pointer moves only when i_advance is asserted.
// After reset the pointer says "requester 1 was served last", so requester 0
// wins the first tie.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid[1:0]   : request lines
//   i_advance      : the current grant is being consumed this cycle
//   o_grant[1:0]   : one-hot grant (zero when no request)
//   o_id           : index of the granted requester
// ---------------------------------------------------------------------------
module lcd_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_id
);

    logic r_last;

    always_comb begin
        o_id = 1'b0;
        if (i_valid == 2'b11) begin
            o_id = ~r_last;
        end else if (i_valid[1]) begin
            o_id = 1'b1;
        end
        o_grant = (i_valid == 2'b00) ? 2'b00 : (o_id ? 2'b10 : 2'b01);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_advance && (i_valid != 2'b00)) begin
            r_last <= o_id;
        end
    end

endmodule

// File: rtl/lcd_bus_sched.sv
// ---------------------------------------------------------------------------
// lcd_bus_sched
// Sequencer plus 2-way round-robin arbiter driving an HD44780-style 8-bit LCD
// write bus. Each accepted {rs, data} transfer produces:
//   SETUP (E_SETUP_CYC, E=0) -> PULSE (E_HIGH_CYC, E=1) -> HOLD (1, E=0)
//   -> WAIT (CLR_WAIT_CYC for clear/home, else CMD_WAIT_CYC) -> IDLE.
// Optional feature macro: LCD_INIT_SEQ_EN. When defined, the block issues
// 0x38, 0x0C, 0x06, 0x01 on its own after power-up before serving requests.
//
// Handshake: reqX_valid/reqX_ready. ready is combinational and high for one
// cycle only in IDLE for the granted requester; data and rs are sampled on
// that cycle only. valid may be withdrawn at any time without acceptance.
//
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   reqX_valid/rs/data/ready (X=0,1): requester interfaces
//   RS, RW, E, D                    : LCD pins (RW tied 0, write-only)
//   busy                            : state != IDLE
//   grant_id                        : requester owning current/last transfer
// ---------------------------------------------------------------------------
module lcd_bus_sched
    import lcd_pkg::*;
#(
    parameter int E_SETUP_CYC    = 2,
    parameter int E_HIGH_CYC     = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLR_WAIT_CYC   = 82000,
    parameter int PWRUP_WAIT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] D,
    output logic       busy,
    output logic       grant_id
);

    localparam int MAX_CYC = lcd_max(lcd_max(lcd_max(E_SETUP_CYC, E_HIGH_CYC),
                                             lcd_max(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                     PWRUP_WAIT_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    lcd_state_e  r_state;
    lcd_state_e  w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_load;
    logic        r_rs;
    logic [7:0]  r_d;
    logic        r_e;
    logic        r_gid;
    logic [1:0]  w_valid;
    logic [1:0]  w_grant;
    logic        w_gid;
    logic        w_accept;
    lcd_xfer_t   w_sel;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0]  r_init_idx;
    logic        w_init_pending;
    assign w_init_pending = (r_init_idx < 3'(LCD_INIT_LEN));
`endif

    assign w_valid = {req1_valid, req0_valid};

    lcd_rr_arb u_arb (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_valid   (w_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_id      (w_gid)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_PWRUP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; timed states leave when the counter reaches zero
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PWRUP: if (r_cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                w_next = ST_INIT;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_IDLE:  if (w_valid != 2'b00) w_next = ST_SETUP;
            ST_SETUP: if (r_cnt == '0) w_next = ST_PULSE;
            ST_PULSE: if (r_cnt == '0) w_next = ST_HOLD;
            ST_HOLD:  w_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                w_next = w_init_pending ? ST_INIT : ST_IDLE;
`else
                w_next = ST_IDLE;
`endif
            end
`ifdef LCD_INIT_SEQ_EN
            ST_INIT:  w_next = ST_SETUP;
`endif
            default:  w_next = ST_PWRUP;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && (w_valid != 2'b00);
        req0_ready = w_accept && w_grant[0];
        req1_ready = w_accept && w_grant[1];
        busy       = (r_state != ST_IDLE);
        w_sel      = w_grant[1] ? lcd_xfer_t'({req1_rs, req1_data})
                                : lcd_xfer_t'({req0_rs, req0_data});
    end

    // Duration-1 of the state being entered; HOLD/INIT last one cycle.
    // The WAIT length is decided from the byte already on the bus.
    always_comb begin
        w_cnt_load = '0;
        case (w_next)
            ST_PWRUP: w_cnt_load = CW'(PWRUP_WAIT_CYC - 1);
            ST_SETUP: w_cnt_load = CW'(E_SETUP_CYC - 1);
            ST_PULSE: w_cnt_load = CW'(E_HIGH_CYC - 1);
            ST_WAIT:  w_cnt_load = lcd_is_long(lcd_xfer_t'({r_rs, r_d}))
                                   ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
            default:  w_cnt_load = '0;
        endcase
    end

    // Single shared down-counter, reloaded on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CW'(PWRUP_WAIT_CYC - 1);
        end else if (w_next != r_state) begin
            r_cnt <= w_cnt_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Bus registers. E is registered from the next state so the pin is a
    // clean flop output; the async reset drops it immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs  <= 1'b0;
            r_d   <= 8'h00;
            r_e   <= 1'b0;
            r_gid <= 1'b0;
        end else begin
            r_e <= (w_next == ST_PULSE);
            if (w_accept) begin
                r_rs  <= w_sel.rs;
                r_d   <= w_sel.data;
                r_gid <= w_gid;
            end
`ifdef LCD_INIT_SEQ_EN
            if (r_state == ST_INIT) begin
                r_rs <= 1'b0;
                r_d  <= LCD_INIT_ROM[r_init_idx[1:0]];
            end
`endif
        end
    end

`ifdef LCD_INIT_SEQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_idx <= 3'd0;
        end else if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + 3'd1;
        end
    end
`endif

    assign RS       = r_rs;
    assign RW       = 1'b0;
    assign E        = r_e;
    assign D        = r_d;
    assign grant_id = r_gid;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_sched
// Cycle-level reference model: every started transfer is described by
// timestamps (when E rises/falls, when the bus is free again) computed from
// the timing parameters; expected pin values each cycle follow from those.
// Accepted transfers are queued and matched against the bus at each E rise.
// ---------------------------------------------------------------------------
module tb_lcd_bus_sched;

    localparam int S   = 2;
    localparam int H   = 4;
    localparam int CMD = 10;
    localparam int CLR = 50;
    localparam int PW  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       RS, RW, E, busy, grant_id;
    logic [7:0] D;

    always #5 clk = ~clk;

    lcd_bus_sched #(
        .E_SETUP_CYC(S), .E_HIGH_CYC(H), .CMD_WAIT_CYC(CMD),
        .CLR_WAIT_CYC(CLR), .PWRUP_WAIT_CYC(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .RS(RS), .RW(RW), .E(E), .D(D), .busy(busy), .grant_id(grant_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    // model state
    int         n;
    int         e_lo, e_hi, next_free, init_left;
    logic       m_rs, m_gid, m_last, m_e_now, prev_e;
    logic [7:0] m_d;
    int         acc_cnt0 = 0;
    int         acc_cnt1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        e_lo = 0;
        e_hi = 0;
        next_free = PW;
`ifdef LCD_INIT_SEQ_EN
        init_left = 4;
`else
        init_left = 0;
`endif
        m_rs = 1'b0;
        m_d = 8'h00;
        m_gid = 1'b0;
        m_last = 1'b1;
        m_e_now = 1'b0;
        prev_e = 1'b0;
        exp_q.delete();
    endtask

    // Called once per cycle at the falling edge.
    task automatic step();
        logic       idle, start, exp_e;
        logic [1:0] er;
        logic [8:0] x;
        int         g;
        if (!rst) begin
            model_reset();
            return;
        end
        exp_e   = (n >= e_lo) && (n < e_hi);
        m_e_now = exp_e;
        check_eq("E", E, exp_e);
        check_eq("RS", RS, m_rs);
        check_eq("D", D, m_d);
        check_eq("RW", RW, 0);
        check_eq("grant_id", grant_id, m_gid);
        if (E && !prev_e) begin
            if (exp_q.size() > 0) check_eq("strobe_byte", {RS, D}, exp_q.pop_front());
            else check_eq("strobe_extra", E, 0);
        end
        prev_e = E;

        idle  = (n >= next_free) && (init_left == 0);
        er    = 2'b00;
        start = 1'b0;
        x     = 9'h0;
        if ((n >= next_free) && (init_left > 0)) begin
            x = {1'b0, rom[4 - init_left]};
            init_left--;
            start = 1'b1;
        end else if (idle && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) g = (m_last == 1'b0) ? 1 : 0;
            else g = req1_valid ? 1 : 0;
            er = (g == 1) ? 2'b10 : 2'b01;
            x  = (g == 1) ? {req1_rs, req1_data} : {req0_rs, req0_data};
            m_last = (g == 1);
            m_gid  = (g == 1);
            if (g == 1) acc_cnt1++; else acc_cnt0++;
            start = 1'b1;
        end
        check_eq("ready", {req1_ready, req0_ready}, er);
        check_eq("busy", busy, !idle);
        if (start) begin
            exp_q.push_back(x);
            m_rs = x[8];
            m_d  = x[7:0];
            e_lo = n + 1 + S;
            e_hi = e_lo + H;
            next_free = e_hi + 1 + (((x[8] == 1'b0) && (x[7:2] == 6'd0)) ? CLR : CMD);
        end
        n++;
    endtask

    task automatic cycle();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input int pct);
        req0_valid = ($urandom_range(0, 99) < pct);
        req1_valid = ($urandom_range(0, 99) < pct);
        req0_rs    = $urandom_range(0, 1);
        req1_rs    = $urandom_range(0, 1);
        req0_data  = 8'($urandom_range(0, 255));
        req1_data  = 8'($urandom_range(0, 255));
        // bias toward clear/home commands so the long wait is exercised
        if ($urandom_range(0, 3) == 0) req0_data = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) req1_data = 8'($urandom_range(0, 3));
    endtask

    logic done;
    logic found;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_E", E, 0);
        check_eq("rst_RS", RS, 0);
        check_eq("rst_D", D, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_ready", {req1_ready, req0_ready}, 0);
        check_eq("rst_grant_id", grant_id, 0);
        step();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed: req0 {1,41} and req1 {0,01} both pending from reset,
        // then req1 {0,80} for the short wait.
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            cycle();
            if (acc_cnt0 >= 1) req0_valid = 1'b0;
            if (acc_cnt1 == 1) req1_data = 8'h80;
            if (acc_cnt1 >= 2) begin
                req1_valid = 1'b0;
                if (n >= next_free) done = 1'b1;
            end
        end
        check_eq("directed_done", done, 1);

        // Both requesters saturated: grants must alternate
        for (int i = 0; i < 400; i++) begin
            drive_random(100);
            cycle();
        end

        // Sparse, short valid pulses (many land while busy)
        for (int i = 0; i < 600; i++) begin
            drive_random(25);
            cycle();
        end

        // Asynchronous reset in the middle of an E pulse
        found = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            step();
            if (m_e_now) begin
                found = 1'b1;
                #2 rst = 1'b0;
                #1;
                check_eq("arst_E", E, 0);
                check_eq("arst_RS", RS, 0);
                check_eq("arst_D", D, 0);
                check_eq("arst_busy", busy, 1);
                check_eq("arst_ready", {req1_ready, req0_ready}, 0);
                check_eq("arst_grant_id", grant_id, 0);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("arst_hit_pulse", found, 1);
        repeat (3) cycle();
        rst = 1'b1;

        // Power-up repeats, then mixed traffic
        for (int i = 0; i < 400; i++) begin
            drive_random(50);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
